band_capture: RTL and testbench
===============================

BAND_CAPTURE -- requirements
Module: band_capture

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 4036, giving the number of 16-bit capture samples.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), giving the buffer address width.
REQ-003 The block SHALL have parameter CNT_WIDTH, default $clog2(MEM_DEPTH+1), giving the sample-count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock (4.4 MHz domain); the clock is one, and reset is synchronous and active-high.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a new capture.
REQ-007 The block SHALL have port abort, input, 1 bit: single-cycle request to stop a capture in progress.
REQ-008 The block SHALL have port data_in, input, signed 16 bits: sample from the band stream.
REQ-009 The block SHALL have port valid_in, input, 1 bit: one-cycle strobe qualifying data_in at the 44 kHz rate.
REQ-010 The block SHALL have port rd_en, input, 1 bit: readback request.
REQ-011 The block SHALL have port rd_addr, input, ADDR_WIDTH bits: readback address.
REQ-012 The block SHALL have port rd_data, output, signed 16 bits: readback sample.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: rd_data qualifier.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in CAPTURE.
REQ-015 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag for samples dropped while in DONE.
REQ-017 The block SHALL have port sample_count, output, CNT_WIDTH bits: number of samples written in the current or most recent capture.

Function
REQ-018 The block SHALL contain an internal single-write, single-read RAM of MEM_DEPTH x 16 with a registered read and no vendor IP.
REQ-019 The FSM SHALL have exactly three states: IDLE, CAPTURE and DONE; busy SHALL be (state==CAPTURE) and done SHALL be (state==DONE).
REQ-020 On start in any state, the block SHALL enter CAPTURE on the next cycle, clear wr_addr to 0, clear sample_count to 0, and clear overrun.
REQ-021 A valid_in asserted in the same cycle as start SHALL NOT be written.
REQ-022 In CAPTURE, each cycle with valid_in=1 and start=0 SHALL write data_in to RAM[wr_addr], increment wr_addr, and increment sample_count, all visible the next cycle.
REQ-023 When the write to address MEM_DEPTH-1 occurs, the FSM SHALL enter DONE next cycle with sample_count=MEM_DEPTH; wr_addr SHALL NOT wrap, and there SHALL be no further writes.
REQ-024 When abort=1 in CAPTURE with start=0, the FSM SHALL go to IDLE next cycle; a valid_in in that same cycle SHALL NOT be written; sample_count SHALL be retained.
REQ-025 abort SHALL be ignored in IDLE and DONE; start SHALL take priority over abort.
REQ-026 In IDLE, valid_in SHALL be ignored with no flag change.
REQ-027 In DONE, valid_in SHALL set overrun=1 next cycle and perform no write; overrun SHALL hold until start or rst.
REQ-028 Readback SHALL be allowed in every state: rd_en=1 in cycle N SHALL produce rd_data=RAM[rd_addr] and rd_valid=1 in cycle N+1; rd_valid SHALL be 0 otherwise.
REQ-029 rd_data SHALL hold its last value while rd_valid=0.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-031 An rd_addr >= MEM_DEPTH SHALL return an undefined rd_data value but SHALL still assert rd_valid.
REQ-032 Consecutive valid_in strobes on back-to-back cycles SHALL each be written, giving full throughput of one sample per clock.

Reset
REQ-033 rst=1 at a clock edge SHALL set state=IDLE, wr_addr=0, sample_count=0, overrun=0, rd_valid=0, rd_data=0, busy=0, and done=0.
REQ-034 Reset SHALL take priority over start, abort, valid_in and rd_en.
REQ-035 Reset mid-capture SHALL abandon the capture.
REQ-036 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-037 The bench SHALL check: start, then 4036 valid_in strobes with data_in=i-2000 -> done=1 after the last strobe, sample_count=4036, and readback of addresses 0, 1 and 4035 returning -2000, -1999 and 2035 with a one-cycle latency.
REQ-038 The bench SHALL check: start, 10 strobes, abort together with an 11th strobe -> IDLE, sample_count=10, and address 10 unchanged.
REQ-039 The bench SHALL check: in DONE, one valid_in -> overrun=1 and RAM unchanged; then start -> overrun=0, busy=1, and sample_count=0.
REQ-040 The bench SHALL check: start and valid_in in the same cycle, then 3 strobes -> sample_count=3, with the first written sample at address 0 being the second input.
REQ-041 The bench SHALL check: write to address 5 and rd_en at rd_addr=5 in the same cycle -> rd_data equals the old value, and a following read returns the new value.
REQ-042 The bench SHALL check: rst asserted after 100 strobes mid-capture -> all outputs at reset values next cycle, and a read of address 50 still returns the previously written data.

Source files
------------

// File: rtl/band_capture.sv
// Purpose : one-shot capture of a 44 kHz band stream into a MEM_DEPTH x 16 buffer, readable at any time.
// Latency : a write takes effect at the clock edge that samples valid_in; readback data appears one cycle after rd_en.
// Backpressure : none. Strobes arriving in DONE are dropped and flagged in overrun; strobes arriving in IDLE are dropped silently.
//
// Ports:
//   clk, rst          - system clock; synchronous active-high reset (does not clear the buffer)
//   start, abort      - single-cycle capture control; start wins over abort
//   data_in, valid_in - signed sample and its one-cycle qualifier
//   rd_en, rd_addr    - readback request and address
//   rd_data, rd_valid - registered readback sample; rd_data holds between reads
//   busy, done        - high in CAPTURE and DONE respectively
//   overrun           - sticky: a strobe arrived while the buffer was full
//   sample_count      - samples written in the current or most recent capture
module band_capture #(
   parameter int MEM_DEPTH  = 4036,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic signed [15:0]    data_in,
   input  logic                  valid_in,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic signed [15:0]    rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  sample_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic [CNT_WIDTH-1:0]    count_q;
   logic                    overrun_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    rd_valid_q;
   logic signed [15:0]      rd_data_q;
   logic signed [15:0]      mem [MEM_DEPTH];
   logic                    wr_en;

   // start and abort both veto the strobe of their own cycle; reset vetoes everything.
   assign wr_en = (state_q == ST_CAPTURE) && valid_in && !start && !abort && !rst;

   // Control FSM. busy/done are registered alongside the state so they change
   // on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_addr_q <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (start) begin
         state_q   <= ST_CAPTURE;
         wr_addr_q <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_CAPTURE: begin
               if (abort) begin
                  // sample_count is kept so software can see how far the capture got
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (valid_in) begin
                  count_q <= count_q + CNT_ONE;
                  if (wr_addr_q == LAST_ADDR) begin
                     // buffer full: park the address rather than wrap
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     wr_addr_q <= wr_addr_q + ADDR_ONE;
                  end
               end
            end
            ST_DONE: begin
               if (valid_in) begin
                  overrun_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Capture buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr_q] <= data_in;
      end
   end

   // Registered read port. Non-blocking semantics give read-before-write on
   // an address collision, so the old sample is returned.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= mem[rd_addr];
         end
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overrun      = overrun_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_band_capture.sv
// Purpose : self-checking bench for band_capture against a behavioural buffer model.
// Latency : every cycle's outputs are compared 1 time unit after the clock edge.
// Backpressure : n/a (bench drives all inputs directly).
module tb_band_capture;

   localparam int DEPTH = 4036;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic signed [15:0]   data_in = '0;
   logic                 valid_in = 1'b0;
   logic                 rd_en = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic signed [15:0]   rd_data;
   logic                 rd_valid;
   logic                 busy;
   logic                 done;
   logic                 overrun;
   logic [CW-1:0]        sample_count;

   always #5 clk = ~clk;

   band_capture #(.MEM_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun),
      .sample_count (sample_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The buffer is a list filled from index 0; its fill level is the sample count.
   typedef enum int {M_IDLE, M_CAPT, M_FULL} mode_t;
   mode_t m_mode      = M_IDLE;
   int    m_mem [DEPTH];
   bit    m_known [DEPTH];
   int    m_count     = 0;
   bit    m_ovr       = 1'b0;
   bit    m_rdv       = 1'b0;
   int    m_rdd       = 0;
   bit    m_rdd_known = 1'b0;
   string phase       = "init";

   task automatic model_step(input bit r, input bit s, input bit a, input bit v,
                             input int d, input bit re, input int ra);
      if (r) begin
         m_mode = M_IDLE; m_count = 0; m_ovr = 1'b0;
         m_rdv = 1'b0; m_rdd = 0; m_rdd_known = 1'b1;
         return;
      end
      // read sees the buffer before this cycle's write
      m_rdv = re;
      if (re) begin
         if (ra < DEPTH) begin
            m_rdd = m_mem[ra]; m_rdd_known = m_known[ra];
         end else begin
            m_rdd_known = 1'b0;
         end
      end
      if (s) begin
         m_mode = M_CAPT; m_count = 0; m_ovr = 1'b0;
      end else if (m_mode == M_CAPT) begin
         if (a) begin
            m_mode = M_IDLE;
         end else if (v) begin
            m_mem[m_count] = d; m_known[m_count] = 1'b1;
            m_count++;
            if (m_count == DEPTH) m_mode = M_FULL;
         end
      end else if (m_mode == M_FULL && v) begin
         m_ovr = 1'b1;
      end
   endtask

   // One clock: drive inputs, advance DUT and model, compare all outputs.
   task automatic cyc(input bit r, input bit s, input bit a, input bit v,
                      input int d, input bit re, input int ra);
      rst = r; start = s; abort = a; valid_in = v;
      data_in = 16'(d); rd_en = re; rd_addr = AW'(ra);
      @(posedge clk);
      model_step(r, s, a, v, d, re, ra);
      #1;
      chk({phase, ":busy"},     busy,         int'(m_mode == M_CAPT));
      chk({phase, ":done"},     done,         int'(m_mode == M_FULL));
      chk({phase, ":overrun"},  overrun,      int'(m_ovr));
      chk({phase, ":count"},    sample_count, m_count);
      chk({phase, ":rd_valid"}, rd_valid,     int'(m_rdv));
      if (m_rdd_known) chk({phase, ":rd_data"}, rd_data, m_rdd);
   endtask

   task automatic idle();              cyc(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic strobe(input int d); cyc(0, 0, 0, 1, d, 0, 0); endtask
   task automatic rd(input int a);     cyc(0, 0, 0, 0, 0, 1, a); endtask

   initial begin
      // reset
      phase = "reset";
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 9, 1, 3);   // reset beats every other input
      chk("rst_busy", busy, 0);
      chk("rst_rd_data", rd_data, 0);
      idle();

      // full fill with data i-2000
      phase = "fill";
      cyc(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) strobe(i - 2000);
      chk("fill_done", done, 1);
      chk("fill_count", sample_count, DEPTH);
      rd(0);
      chk("fill_rdv0", rd_valid, 1);
      chk("fill_rd0", rd_data, -2000);
      rd(1);
      chk("fill_rd1", rd_data, -1999);
      rd(DEPTH - 1);
      chk("fill_rdlast", rd_data, 2035);
      idle();
      chk("fill_rdv_drop", rd_valid, 0);
      chk("fill_rd_hold", rd_data, 2035);
      cyc(0, 0, 1, 0, 0, 0, 0);   // abort ignored in DONE
      chk("done_abort_ign", done, 1);

      // overrun in DONE, then restart
      phase = "overrun";
      strobe(1234);
      chk("ovr_set", overrun, 1);
      idle();
      chk("ovr_sticky", overrun, 1);
      rd(0);
      chk("ovr_ram0", rd_data, -2000);
      rd(DEPTH - 1);
      chk("ovr_ramlast", rd_data, 2035);
      cyc(0, 1, 1, 0, 0, 0, 0);   // start wins over abort
      chk("restart_ovr", overrun, 0);
      chk("restart_busy", busy, 1);
      chk("restart_count", sample_count, 0);

      // abort with an 11th strobe
      phase = "abort";
      for (int i = 0; i < 10; i++) strobe(100 + i);
      cyc(0, 0, 1, 1, 7777, 0, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count", sample_count, 10);
      cyc(0, 0, 1, 1, 8888, 0, 0); // abort and strobe ignored in IDLE
      chk("idle_count", sample_count, 10);
      rd(10);
      chk("abort_addr10", rd_data, 10 - 2000);

      // start together with a strobe
      phase = "start_strobe";
      cyc(0, 1, 0, 1, 555, 0, 0);
      strobe(1); strobe(2); strobe(3);
      chk("ss_count", sample_count, 3);
      rd(0);
      chk("ss_addr0", rd_data, 1);
      rd(3);
      chk("ss_addr3", rd_data, 103);

      // same-address read/write collision at address 5
      phase = "collide";
      strobe(40); strobe(50);
      cyc(0, 0, 0, 1, 60, 1, 5);
      chk("col_old", rd_data, 105);
      rd(5);
      chk("col_new", rd_data, 60);

      // reset mid-capture
      phase = "mid_reset";
      cyc(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) strobe(i * 3 - 77);
      cyc(1, 0, 0, 1, 999, 1, 2);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_ovr", overrun, 0);
      chk("mr_count", sample_count, 0);
      chk("mr_rdv", rd_valid, 0);
      chk("mr_rdd", rd_data, 0);
      rd(50);
      chk("mr_keep50", rd_data, 73);

      // out-of-range read still strobes rd_valid
      phase = "oor";
      rd((1 << AW) - 1);
      chk("oor_rdv", rd_valid, 1);

      // randomized mix
      phase = "random";
      for (int n = 0; n < 4000; n++) begin
         bit r, s, a, v, re;
         r  = ($urandom_range(0, 511) == 0);
         s  = ($urandom_range(0, 63) == 0);
         a  = ($urandom_range(0, 63) == 0);
         v  = ($urandom_range(0, 1) == 1);
         re = ($urandom_range(0, 1) == 1);
         cyc(r, s, a, v, int'($urandom_range(0, 65535)) - 32768, re,
             int'($urandom_range(0, 200)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
